conv1_frame_ctrl: RTL and testbench

Frame sequencer for the first convolution stage. It accepts one IMG_W×IMG_H 8-bit image per `start` over a valid/ready pixel stream and forwards exactly IMG_W·IMG_H pixels to the conv1 layer's `in_valid`/`data_in`. It then counts the conv1 layer's `out_valid` pulses, tagging each output with its (row, col) coordinate for the downstream pooling stage. It signals `frame_done` once all (IMG_W−K+1)·(IMG_H−K+1) outputs have arrived.

---
 rtl/conv1_frame_ctrl_if.sv | 26 ++
 rtl/conv1_frame_ctrl.sv | 127 ++++++++++++
 tb/tb_conv1_frame_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1_frame_ctrl_if.sv
// Pixel-stream, conv1-handshake and status bundle for the conv1 frame sequencer.
// No logic: the master side is the frame source / conv1 model, the slave side is the sequencer.
interface conv1_frame_ctrl_if;
    logic       start;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;
    logic       conv_in_valid;
    logic [7:0] conv_data_in;
    logic       conv_out_valid;
    logic [4:0] out_row;
    logic [4:0] out_col;
    logic       busy;
    logic       frame_done;
    logic       err;

    modport master (
        output start, pix_valid, pix_data, conv_out_valid,
        input  pix_ready, conv_in_valid, conv_data_in, out_row, out_col, busy, frame_done, err
    );

    modport slave (
        input  start, pix_valid, pix_data, conv_out_valid,
        output pix_ready, conv_in_valid, conv_data_in, out_row, out_col, busy, frame_done, err
    );
endinterface

// File: rtl/conv1_frame_ctrl.sv
// Frame sequencer for conv1: streams IMG_W*IMG_H pixels in, tags conv1 outputs with (row, col).
// Latency: pixel to conv_in_valid/conv_data_in is 1 cycle; frame_done 1 cycle after the last output.
// Backpressure: pix_ready only in LOAD; optional drain watchdog under CONV1_CTRL_TIMEOUT_EN.
module conv1_frame_ctrl #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int K       = 5,
    parameter int CW      = 10,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    conv1_frame_ctrl_if.slave io
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam logic [CW-1:0] PIX_LAST = CW'(IMG_W * IMG_H - 1);
    localparam logic [4:0]    COL_LAST = 5'(OUT_W - 1);
    localparam logic [4:0]    ROW_LAST = 5'(OUT_H - 1);

    if (CW < $clog2(IMG_W * IMG_H)) begin : g_bad_cw
        $error("CW too narrow for IMG_W*IMG_H-1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] pix_cnt;
    logic          pix_acc;
    logic          cnt_en;
    logic          out_last;

    assign io.pix_ready  = (state == LOAD);
    assign io.busy       = (state == LOAD) || (state == DRAIN);
    assign io.frame_done = (state == DONE);

    assign pix_acc  = io.pix_valid & io.pix_ready;
    assign cnt_en   = io.conv_out_valid && ((state == LOAD) || (state == DRAIN));
    assign out_last = (io.out_row == ROW_LAST) && (io.out_col == COL_LAST);

`ifdef CONV1_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            pix_cnt          <= '0;
            io.conv_in_valid <= 1'b0;
            io.conv_data_in  <= '0;
            io.out_row       <= '0;
            io.out_col       <= '0;
            io.err           <= 1'b0;
`ifdef CONV1_CTRL_TIMEOUT_EN
            wd_cnt           <= '0;
`endif
        end else begin
            io.conv_in_valid <= pix_acc;
            if (pix_acc) begin
                io.conv_data_in <= io.pix_data;
            end

            // Outputs outside an active frame are flagged, never counted.
            if (io.conv_out_valid && ((state == IDLE) || (state == DONE))) begin
                io.err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (io.start) begin
                        state      <= LOAD;
                        pix_cnt    <= '0;
                        io.out_row <= '0;
                        io.out_col <= '0;
                    end
                end
                LOAD: begin
                    if (pix_acc) begin
                        if (pix_cnt == PIX_LAST) begin
                            state <= DRAIN;
`ifdef CONV1_CTRL_TIMEOUT_EN
                            wd_cnt <= '0;
`endif
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
`ifdef CONV1_CTRL_TIMEOUT_EN
                    if (io.conv_out_valid) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        io.err <= 1'b1;
                        state  <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // The final output closes the frame even if pixels are still loading.
            if (cnt_en) begin
                if (io.out_col == COL_LAST) begin
                    io.out_col <= '0;
                    io.out_row <= io.out_row + 5'd1;
                end else begin
                    io.out_col <= io.out_col + 5'd1;
                end
                if (out_last) begin
                    state <= DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// Directed bench for conv1_frame_ctrl with a small conv1 model (fixed 3-cycle output latency).
module tb_conv1_frame_ctrl;
    localparam int NPIX = 784;
    localparam int NOUT = 576;
    localparam int OW   = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv1_frame_ctrl_if bus();

    conv1_frame_ctrl #(
        .IMG_W(28), .IMG_H(28), .K(5), .CW(10), .TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // conv1 model: every forwarded pixel with row>=4 and col>=4 yields one output 3 cycles later.
    logic       model_ov = 1'b0;
    logic       stray_ov = 1'b0;
    logic [2:0] dl       = '0;
    logic       acc_prev = 1'b0;
    logic       pend_done = 1'b0;
    bit         mon_en   = 1'b0;
    bit         chk_done = 1'b1;
    int         in_cnt   = 0;
    int         out_cnt  = 0;
    int         out_limit = NOUT;
    int         frame_id = 0;
    int         seen_id  = 0;

    assign bus.conv_out_valid = model_ov | stray_ov;

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                dl        = '0;
                model_ov  = 1'b0;
                acc_prev  = 1'b0;
                pend_done = 1'b0;
                in_cnt    = 0;
                out_cnt   = 0;
            end else begin
                if (frame_id != seen_id) begin
                    seen_id = frame_id;
                    in_cnt  = 0;
                    out_cnt = 0;
                end
                check("civ_mirror", bus.conv_in_valid, acc_prev);
                if (chk_done) check("frame_done", bus.frame_done, pend_done);
                pend_done = 1'b0;
                if (bus.conv_in_valid) begin
                    check("conv_data", bus.conv_data_in, in_cnt % 256);
                    dl = {dl[1:0], ((in_cnt / 28) >= 4) && ((in_cnt % 28) >= 4)};
                    in_cnt++;
                end else begin
                    dl = {dl[1:0], 1'b0};
                end
                model_ov = dl[2] && (out_cnt < out_limit);
                if (model_ov) begin
                    check("tag", {bus.out_row, bus.out_col}, {5'(out_cnt / OW), 5'(out_cnt % OW)});
                    out_cnt++;
                    if (out_cnt == NOUT) pend_done = 1'b1;
                end
                acc_prev = bus.pix_valid & bus.pix_ready;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        stray_ov      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic begin_frame();
        bus.start = 1'b1;
        frame_id++;
        tick();
        bus.start = 1'b0;
    endtask

    // Offers pixels until stop_at are accepted; start is re-pulsed when acc == poke.
    task automatic load_pixels(input bit gaps, input int stop_at, input int poke);
        int acc = 0;
        int cyc = 0;
        while (acc < stop_at && cyc < 5000) begin
            bus.pix_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
            bus.pix_data  = 8'(acc);
            bus.start     = (acc == poke);
            if (bus.pix_valid && bus.pix_ready) acc++;
            cyc++;
            tick();
        end
        bus.pix_valid = 1'b0;
        bus.start     = 1'b0;
        check("pix_accepted", acc, stop_at);
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (!bus.frame_done && n < max_cyc) begin
            tick();
            n++;
        end
        check("done_seen", bus.frame_done, 1'b1);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        do_reset();
        mon_en = 1'b1;

        check("rst_pix_ready", bus.pix_ready, 0);
        check("rst_civ", bus.conv_in_valid, 0);
        check("rst_data", bus.conv_data_in, 0);
        check("rst_row", bus.out_row, 0);
        check("rst_col", bus.out_col, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.frame_done, 0);
        check("rst_err", bus.err, 0);

        // Nominal frame
        begin_frame();
        check("busy_load", bus.busy, 1);
        check("ready_load", bus.pix_ready, 1);
        load_pixels(1'b0, NPIX, -1);
        check("ready_drain", bus.pix_ready, 0);
        check("busy_drain", bus.busy, 1);
        wait_done(50);
        check("nom_in_cnt", in_cnt, NPIX);
        check("nom_out_cnt", out_cnt, NOUT);
        check("nom_err", bus.err, 0);
        check("busy_done", bus.busy, 0);
        tick();
        check("idle_busy", bus.busy, 0);

        // Gapped pixel stream
        begin_frame();
        load_pixels(1'b1, NPIX, -1);
        check("pix_cnt_end", dut.pix_cnt, 783);
        wait_done(50);
        check("gap_in_cnt", in_cnt, NPIX);
        check("gap_out_cnt", out_cnt, NOUT);
        tick();

        // Starts in LOAD, DRAIN and DONE are ignored
        begin_frame();
        load_pixels(1'b0, NPIX, 100);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("drain_start_busy", bus.busy, 1);
        wait_done(50);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("done_start_busy", bus.busy, 0);
        tick();
        check("no_restart_busy", bus.busy, 0);
        check("no_restart_ready", bus.pix_ready, 0);
        check("ign_out_cnt", out_cnt, NOUT);
        check("ign_err", bus.err, 0);

        // Stray output in IDLE sets a sticky err
        stray_ov = 1'b1;
        tick();
        stray_ov = 1'b0;
        check("stray_err", bus.err, 1);
        check("stray_busy", bus.busy, 0);
        begin_frame();
        load_pixels(1'b0, NPIX, -1);
        wait_done(50);
        check("stray_out_cnt", out_cnt, NOUT);
        check("err_sticky", bus.err, 1);
        tick();
        do_reset();
        check("err_cleared", bus.err, 0);

        // Mid-frame reset after 300 pixels
        begin_frame();
        load_pixels(1'b0, 300, -1);
        check("mid_row", bus.out_row, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", bus.busy, 0);
        check("mid_ready", bus.pix_ready, 0);
        check("mid_row_clr", bus.out_row, 0);
        check("mid_col_clr", bus.out_col, 0);
        check("mid_civ", bus.conv_in_valid, 0);
        tick();
        begin_frame();
        load_pixels(1'b0, NPIX, -1);
        wait_done(50);
        check("post_in_cnt", in_cnt, NPIX);
        check("post_out_cnt", out_cnt, NOUT);
        check("post_err", bus.err, 0);
        tick();

        // conv1 stalls after 500 outputs
        out_limit = 500;
`ifdef CONV1_CTRL_TIMEOUT_EN
        chk_done = 1'b0;
`endif
        begin_frame();
        load_pixels(1'b0, NPIX, -1);
`ifdef CONV1_CTRL_TIMEOUT_EN
        begin
            int n = 0;
            while (!bus.frame_done && n < 200) begin
                tick();
                n++;
            end
            check("wd_cycles", n, 64);
            check("wd_err", bus.err, 1);
            tick();
            check("wd_idle", bus.busy, 0);
        end
`else
        repeat (200) tick();
        check("stall_busy", bus.busy, 1);
        check("stall_done", bus.frame_done, 0);
        check("stall_err", bus.err, 0);
`endif
        check("stall_out_cnt", out_cnt, 500);
        do_reset();
        check("final_busy", bus.busy, 0);
        out_limit = NOUT;
        chk_done  = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
